lcd_hd44780_ctrl: RTL and testbench
===================================

# lcd_hd44780_ctrl

Parametrised HD44780-compatible character LCD controller in 8-bit mode. It runs the power-up wait and the initialisation command sequence, then accepts command or data bytes over a valid/ready handshake. Each byte is driven with programmable setup, enable-pulse and hold timing, followed by a post-write wait. It replaces per-design hand-coded LCD counters. Display formatters (clock, stopwatch, status) sit upstream; the LCD pins sit downstream.

## Interface
Parameters:
- CLK_HZ, 50_000_000, clock frequency. Must be a multiple of 1_000_000.
- POWERUP_US, 15000, wait after reset release before the first init command.
- CMD_WAIT_US, 40, post-write wait for ordinary commands and data.
- CLEAR_WAIT_US, 1640, post-write wait for clear/home commands.
- SETUP_CYC, 20, cycles that RS/data are stable before EN rises.
- EN_HIGH_CYC, 75, EN high width in cycles.
- HOLD_CYC, 20, cycles that RS/data are held after EN falls.
- DISPLAY_CTRL, 8'h0C, display-control byte sent during init.
- ENTRY_MODE, 8'h06, entry-mode byte sent during init.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a byte is offered.
- in_rs  in  1  0 = command, 1 = character data.
- in_data  in  8  byte to write.
- in_ready  out  1  controller accepts a byte this cycle.
- init_done  out  1  init sequence has completed; remains 1 until reset.
- LCD_DataBus  out  8  LCD D7..D0.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  tied to 0 (write only).
- LCD_EN  out  1  enable strobe.
- LCD_ON  out  1  LCD power/backlight enable.

## Operation
- Derived cycle counts: a US parameter becomes CLK_HZ/1_000_000*US cycles, clamped to a minimum of 1. A single down-counter sized with $clog2 of the largest count serves every phase.
- State machine:
  - PWRUP → INIT_SETUP → INIT_EN → INIT_HOLD → INIT_WAIT. The INIT loop runs six times, then goes to IDLE.
  - IDLE → W_SETUP → W_EN → W_HOLD → W_WAIT → IDLE.
- Init byte order (RS=0): 0x38, 0x38, 0x38, DISPLAY_CTRL, 0x01, ENTRY_MODE.
- Long-wait rule: the write uses CLEAR_WAIT when RS=0 and the byte is 0x01, 0x02 or 0x03. Every other byte uses CMD_WAIT, including command 0x00.
- Handshake:
  - in_ready = 1 only in IDLE.
  - A transfer occurs when in_valid & in_ready are both 1 on a rising edge. in_rs and in_data are registered on that edge.
  - in_ready drops on the next cycle.
  - in_valid is ignored when in_ready = 0, so nothing is queued.
- Bus holding: LCD_DataBus and LCD_RS keep the last written value through the wait and IDLE, until the next accepted byte.
- Reset values: LCD_DataBus 0, LCD_RS 0, LCD_RW 0, LCD_EN 0, LCD_ON 0, in_ready 0, init_done 0. The state is PWRUP.
- LCD_ON goes to 1 on the first rising edge after rst_n deasserts and stays 1.
- Reset mid-operation: asserting rst_n forces every output to its reset value immediately, without waiting for a clock. Any in-flight byte is dropped. The full power-up and init sequence repeats after release.

## Timing
- Cycle 0 is the first rising edge with rst_n high.
- PWRUP lasts P = POWERUP cycles (cycles 0..P-1).
- A write of byte k occupies, from its first SETUP cycle:
  - SETUP_CYC cycles with EN = 0 and RS/data driven;
  - then EN_HIGH_CYC cycles with EN = 1;
  - then HOLD_CYC cycles with EN = 0;
  - then W wait cycles, where W is CMD_WAIT or CLEAR_WAIT.
- Let S = SETUP_CYC + EN_HIGH_CYC + HOLD_CYC.
- IDLE, with init_done = 1 and in_ready = 1, is first entered at cycle P + 6S + 5·CMD_WAIT + CLEAR_WAIT.
- After an accept at edge T:
  - LCD_DataBus and LCD_RS take the new values at T+1.
  - LCD_EN is high from T+1+SETUP_CYC through T+SETUP_CYC+EN_HIGH_CYC.
  - in_ready returns to 1 at T+1+S+W.
- Back-to-back throughput: one byte per S+W+1 cycles while in_valid is held high.

## Test plan
Bench parameters: CLK_HZ=1_000_000, POWERUP_US=10, CMD_WAIT_US=4, CLEAR_WAIT_US=16, SETUP_CYC=2, EN_HIGH_CYC=3, HOLD_CYC=2. This gives S=7, a normal write of 11 cycles and a clear of 23 cycles.

- **Reset and init:** release rst_n; capture LCD_DataBus on each LCD_EN rising edge.
  - Required: exactly 6 EN pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all with RS=0.
  - init_done and in_ready rise at cycle 88. LCD_ON = 1 from cycle 0.
- **Data write:** offer in_rs=1, in_data=0x41 at IDLE edge T.
  - Required: RS=1 and bus=0x41 at T+1; EN high exactly at T+3..T+5; in_ready = 1 again at T+12.
  - The bus still reads 0x41 afterwards.
- **Long wait:** send command 0x01 → in_ready returns at T+24. Send command 0x02 → T+24. Send command 0x04 → T+12. Send data 0x01 (RS=1) → T+12.
- **Stream:** hold in_valid high with 4 bytes 0x30..0x33 → accepts occur at 12-cycle spacing. Each byte is seen exactly once, with no duplicates or drops.
- **Ignored valid:** pulse in_valid with 0x55 during a write's EN phase → no extra EN pulse; the bus never shows 0x55.
- **Mid-operation reset:** assert rst_n during the EN-high phase of an init write.
  - Required: LCD_EN, LCD_ON, in_ready and init_done are 0 before the next clock edge.
  - After release, the full 6-command init repeats, and init_done rises 88 cycles after release.

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character LCD controller, 8-bit write-only mode.
// Power-up wait, six-byte init, then valid/ready byte writes.
module lcd_hd44780_ctrl #(
  parameter int          CLK_HZ        = 50_000_000,
  parameter int          POWERUP_US    = 15000,
  parameter int          CMD_WAIT_US   = 40,
  parameter int          CLEAR_WAIT_US = 1640,
  parameter int          SETUP_CYC     = 20,
  parameter int          EN_HIGH_CYC   = 75,
  parameter int          HOLD_CYC      = 20,
  parameter logic [7:0]  DISPLAY_CTRL  = 8'h0C,
  parameter logic [7:0]  ENTRY_MODE    = 8'h06
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic [7:0] LCD_DataBus,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON
);

  localparam int CPU   = CLK_HZ / 1_000_000;
  localparam int PWR_C = (CPU * POWERUP_US < 1) ? 1 : CPU * POWERUP_US;
  localparam int CMD_C = (CPU * CMD_WAIT_US < 1) ? 1 : CPU * CMD_WAIT_US;
  localparam int CLR_C = (CPU * CLEAR_WAIT_US < 1) ? 1 : CPU * CLEAR_WAIT_US;
  localparam int SET_C = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
  localparam int ENH_C = (EN_HIGH_CYC < 1) ? 1 : EN_HIGH_CYC;
  localparam int HLD_C = (HOLD_CYC < 1) ? 1 : HOLD_CYC;

  localparam int M1    = (PWR_C > CMD_C) ? PWR_C : CMD_C;
  localparam int M2    = (M1 > CLR_C) ? M1 : CLR_C;
  localparam int M3    = (M2 > SET_C) ? M2 : SET_C;
  localparam int M4    = (M3 > ENH_C) ? M3 : ENH_C;
  localparam int MAX_C = (M4 > HLD_C) ? M4 : HLD_C;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t PWR_L = cnt_t'(PWR_C - 1);
  localparam cnt_t CMD_L = cnt_t'(CMD_C - 1);
  localparam cnt_t CLR_L = cnt_t'(CLR_C - 1);
  localparam cnt_t SET_L = cnt_t'(SET_C - 1);
  localparam cnt_t ENH_L = cnt_t'(ENH_C - 1);
  localparam cnt_t HLD_L = cnt_t'(HLD_C - 1);

  typedef enum logic [3:0] {
    PWRUP, INIT_SETUP, INIT_EN, INIT_HOLD, INIT_WAIT,
    IDLE, W_SETUP, W_EN, W_HOLD, W_WAIT
  } state_t;

  state_t     state, state_n;
  cnt_t       cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] bus_n;
  logic       rs_n, done_n, en_n, last, long_w;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd3:    init_byte = DISPLAY_CTRL;
      3'd4:    init_byte = 8'h01;
      3'd5:    init_byte = ENTRY_MODE;
      default: init_byte = 8'h38;
    endcase
  endfunction

  assign last     = (cnt == '0);
  // The bus still holds the byte being written, so it picks the wait.
  assign long_w   = !LCD_RS &&
                    (LCD_DataBus inside {8'h01, 8'h02, 8'h03});
  assign in_ready = (state == IDLE);
  assign LCD_RW   = 1'b0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt - 1'b1;
    idx_n   = idx;
    bus_n   = LCD_DataBus;
    rs_n    = LCD_RS;
    done_n  = init_done;
    unique case (state)
      PWRUP: if (last) begin
        state_n = INIT_SETUP;
        cnt_n   = SET_L;
        idx_n   = 3'd0;
        bus_n   = init_byte(3'd0);
        rs_n    = 1'b0;
      end
      INIT_SETUP: if (last) begin
        state_n = INIT_EN;
        cnt_n   = ENH_L;
      end
      INIT_EN: if (last) begin
        state_n = INIT_HOLD;
        cnt_n   = HLD_L;
      end
      INIT_HOLD: if (last) begin
        state_n = INIT_WAIT;
        cnt_n   = long_w ? CLR_L : CMD_L;
      end
      INIT_WAIT: if (last) begin
        if (idx == 3'd5) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = INIT_SETUP;
          cnt_n   = SET_L;
          idx_n   = idx + 3'd1;
          bus_n   = init_byte(idx + 3'd1);
        end
      end
      IDLE: begin
        cnt_n = cnt;
        if (in_valid) begin
          state_n = W_SETUP;
          cnt_n   = SET_L;
          bus_n   = in_data;
          rs_n    = in_rs;
        end
      end
      W_SETUP: if (last) begin
        state_n = W_EN;
        cnt_n   = ENH_L;
      end
      W_EN: if (last) begin
        state_n = W_HOLD;
        cnt_n   = HLD_L;
      end
      W_HOLD: if (last) begin
        state_n = W_WAIT;
        cnt_n   = long_w ? CLR_L : CMD_L;
      end
      W_WAIT: if (last) begin
        state_n = IDLE;
      end
      default: state_n = PWRUP;
    endcase
    en_n = (state_n == INIT_EN) || (state_n == W_EN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PWRUP;
      cnt         <= PWR_L;
      idx         <= 3'd0;
      LCD_DataBus <= 8'h00;
      LCD_RS      <= 1'b0;
      LCD_EN      <= 1'b0;
      LCD_ON      <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      LCD_DataBus <= bus_n;
      LCD_RS      <= rs_n;
      LCD_EN      <= en_n;
      LCD_ON      <= 1'b1;
      init_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Randomized bench for lcd_hd44780_ctrl.
// Expected timing comes from the phase-length arithmetic.
module tb_lcd_hd44780_ctrl;

  localparam int SET = 2;
  localparam int ENH = 3;
  localparam int HLD = 2;
  localparam int S   = SET + ENH + HLD;
  localparam int CMD = 4;
  localparam int CLR = 16;
  localparam int P   = 10;
  localparam int INIT_END = P + 6 * S + 5 * CMD + CLR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, init_done;
  logic [7:0] LCD_DataBus;
  logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [8:0] enq[$];
  logic [7:0] exp_init[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_hd44780_ctrl #(
    .CLK_HZ(1_000_000), .POWERUP_US(P), .CMD_WAIT_US(CMD),
    .CLEAR_WAIT_US(CLR), .SETUP_CYC(SET), .EN_HIGH_CYC(ENH),
    .HOLD_CYC(HLD), .DISPLAY_CTRL(8'h0C), .ENTRY_MODE(8'h06)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rs(in_rs),
    .in_data(in_data), .in_ready(in_ready), .init_done(init_done),
    .LCD_DataBus(LCD_DataBus), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_ON(LCD_ON)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge LCD_EN) enq.push_back({LCD_RS, LCD_DataBus});

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? CLR : CMD;
  endfunction

  task automatic run_init(input string tag);
    int done_at;
    done_at = -1;
    enq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 400 && done_at < 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) check({tag, "_on"}, LCD_ON, 1);
      if (init_done) begin
        done_at = k;
        check({tag, "_rdy"}, in_ready, 1);
      end
    end
    // value seen after edge INIT_END-1 is the one present at edge INIT_END
    check({tag, "_done_cyc"}, done_at, INIT_END - 1);
    check({tag, "_npulse"}, enq.size(), 6);
    for (int i = 0; i < 6 && i < enq.size(); i++)
      check({tag, "_byte"}, enq[i], {1'b0, exp_init[i]});
  endtask

  task automatic send(input logic rs, input logic [7:0] d,
                      input bit poke);
    int n, w;
    logic [10:0] want;
    enq.delete();
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wr_rdy", in_ready, 1);
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    w = wait_of(rs, d);
    for (int k = 0; k < S + w; k++) begin
      want = {(k >= SET && k < SET + ENH), 1'b0, rs, d};
      check("wr_cyc", {LCD_EN, in_ready, LCD_RS, LCD_DataBus}, want);
      in_valid = (poke && k == SET);
      if (poke && k == SET) in_data = 8'h55;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("wr_back", {in_ready, LCD_EN, LCD_RS, LCD_DataBus},
          {1'b1, 1'b0, rs, d});
    check("wr_npulse", enq.size(), 1);
    if (enq.size() > 0) check("wr_pulse", enq[0], {rs, d});
  endtask

  task automatic stream();
    int t_prev, t_now, n;
    logic [7:0] b;
    t_prev = 0;
    enq.delete();
    in_rs    = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = 8'h30 + 8'(i);
      in_data = b;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      t_now = cyc;
      check("strm_rdy", in_ready, 1);
      if (i > 0) check("strm_gap", t_now - t_prev, S + CMD + 1);
      t_prev = t_now;
      @(posedge clk);
      #1;
      check("strm_bus", {LCD_RS, LCD_DataBus}, {1'b1, b});
    end
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("strm_end", in_ready, 1);
    check("strm_npulse", enq.size(), 4);
    for (int i = 0; i < 4 && i < enq.size(); i++)
      check("strm_byte", enq[i], {1'b1, 8'h30 + 8'(i)});
  endtask

  initial begin
    logic       r;
    logic [7:0] d;
    int         n;
    repeat (3) @(negedge clk);
    check("rst_vals",
          {LCD_DataBus, LCD_RS, LCD_RW, LCD_EN, LCD_ON, in_ready, init_done},
          0);
    run_init("init");

    send(1'b1, 8'h41, 1'b0);
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h02, 1'b0);
    send(1'b0, 8'h03, 1'b0);
    send(1'b0, 8'h04, 1'b0);
    send(1'b1, 8'h01, 1'b0);
    send(1'b0, 8'h00, 1'b0);
    send(1'b1, 8'h77, 1'b1);

    for (int i = 0; i < 12; i++) begin
      r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(0, 4));
      else d = 8'($urandom);
      send(r, d, ($urandom_range(0, 3) == 0));
    end

    stream();

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    enq.delete();
    n = 0;
    while (enq.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_en_hi", LCD_EN, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst", {LCD_EN, LCD_ON, in_ready, init_done, LCD_RS,
          LCD_DataBus}, 0);
    @(negedge clk);
    run_init("reinit");
    send(1'b1, 8'h5A, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
